// File: rtl/countdown_game_pkg.sv
// Shared types and default parameter values for the countdown reaction game.
package countdown_game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gameState_e;

  localparam int DEF_CLK_PER_MS = 1000;
  localparam int DEF_STEP_MS    = 1000;
  localparam int DEF_STEPS      = 5;
  localparam int DEF_TARGET_MS  = 5000;
  localparam int DEF_TOL_MS     = 100;

  localparam int COUNT_W = 32;

endpackage

// File: rtl/countdown_game_ctrl_if.sv
// Button inputs and display-side outputs of the countdown game controller.
interface countdown_game_ctrl_if;
  import countdown_game_pkg::*;

  logic               START;
  logic               STOP;
  logic [COUNT_W-1:0] COUNT1;
  logic [2:0]         COUNT_DOWN;
  logic [COUNT_W-1:0] ELAPSED;
  logic               RUNNING;
  logic               WIN;
  logic               LOSE;

  modport master (
    output START, STOP,
    input  COUNT1, COUNT_DOWN, ELAPSED, RUNNING, WIN, LOSE
  );

  modport slave (
    input  START, STOP,
    output COUNT1, COUNT_DOWN, ELAPSED, RUNNING, WIN, LOSE
  );

endinterface

// File: rtl/countdown_game_ctrl_ms_tick_gen.sv
// Clock-to-millisecond prescaler: one-cycle tick every CLK_PER_MS cycles.
module ms_tick_gen
  import countdown_game_pkg::*;
#(
  parameter int CLK_PER_MS = DEF_CLK_PER_MS
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  output logic tick
);

  localparam int PW = $clog2(CLK_PER_MS);

  logic [PW-1:0] presc_q, presc_d;

  assign tick = !clear && (presc_q == PW'(CLK_PER_MS - 1));

  // Next prescaler value: held at zero while cleared, wraps after the tick.
  always_comb begin
    presc_d = presc_q;
    if (clear || tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  // Prescaler register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/countdown_game_ctrl.sv
// Countdown reaction game sequencer: FSM, button edge detect, counters, judge.
module countdown_game_ctrl
  import countdown_game_pkg::*;
#(
  parameter int CLK_PER_MS = DEF_CLK_PER_MS,
  parameter int STEP_MS    = DEF_STEP_MS,
  parameter int STEPS      = DEF_STEPS,
  parameter int TARGET_MS  = DEF_TARGET_MS,
  parameter int TOL_MS     = DEF_TOL_MS
) (
  input  logic                 CLK,
  input  logic                 RESET,
  countdown_game_ctrl_if.slave bus
);

  localparam logic [COUNT_W-1:0] TIMEOUT_MS = COUNT_W'(TARGET_MS + TOL_MS + 1);
  localparam logic [COUNT_W:0]   WIN_LO     = (COUNT_W+1)'(TARGET_MS);
  localparam logic [COUNT_W:0]   WIN_HI     = (COUNT_W+1)'(TARGET_MS + TOL_MS);

  gameState_e         state_q, state_d;
  logic               startPrev_q, stopPrev_q;
  logic [COUNT_W-1:0] count1_q, count1_d;
  logic [COUNT_W-1:0] stepCnt_q, stepCnt_d;
  logic [2:0]         countDown_q, countDown_d;
  logic [COUNT_W-1:0] elapsed_q, elapsed_d;
  logic               win_q, win_d;
  logic               lose_q, lose_d;

  logic startEdge, stopEdge, tick, tickClear, withinTol;

  assign startEdge = bus.START && !startPrev_q;
  assign stopEdge  = bus.STOP && !stopPrev_q;
  assign tickClear = (state_q != RUN);

  // Two-sided tolerance window check: TARGET-TOL <= COUNT1 <= TARGET+TOL.
  assign withinTol = (({1'b0, count1_q} + (COUNT_W+1)'(TOL_MS)) >= WIN_LO) &&
                     ({1'b0, count1_q} <= WIN_HI);

  ms_tick_gen #(.CLK_PER_MS(CLK_PER_MS)) u_tick (
    .CLK   (CLK),
    .RESET (RESET),
    .clear (tickClear),
    .tick  (tick)
  );

  // Next-state and datapath: round start, millisecond counting, STOP judge, timeout.
  always_comb begin
    state_d     = state_q;
    count1_d    = count1_q;
    stepCnt_d   = stepCnt_q;
    countDown_d = countDown_q;
    elapsed_d   = elapsed_q;
    win_d       = win_q;
    lose_d      = lose_q;
    case (state_q)
      IDLE, DONE: begin
        if (startEdge) begin
          state_d     = RUN;
          count1_d    = '0;
          stepCnt_d   = '0;
          countDown_d = 3'(STEPS);
          elapsed_d   = '0;
          win_d       = 1'b0;
          lose_d      = 1'b0;
        end
      end
      RUN: begin
        if (stopEdge) begin
          state_d     = DONE;
          elapsed_d   = count1_q;
          win_d       = withinTol;
          lose_d      = !withinTol;
          countDown_d = 3'd0;
        end else if (tick) begin
          if ((count1_q + COUNT_W'(1)) == TIMEOUT_MS) begin
            state_d     = DONE;
            count1_d    = TIMEOUT_MS;
            elapsed_d   = TIMEOUT_MS;
            win_d       = 1'b0;
            lose_d      = 1'b1;
            countDown_d = 3'd0;
          end else begin
            count1_d = count1_q + COUNT_W'(1);
            if (stepCnt_q == COUNT_W'(STEP_MS - 1)) begin
              stepCnt_d = '0;
              if (countDown_q != 3'd0) begin
                countDown_d = countDown_q - 3'd1;
              end
            end else begin
              stepCnt_d = stepCnt_q + COUNT_W'(1);
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers; button copies reset high so a held button does not fire.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      startPrev_q <= 1'b1;
      stopPrev_q  <= 1'b1;
      count1_q    <= '0;
      stepCnt_q   <= '0;
      countDown_q <= 3'd0;
      elapsed_q   <= '0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      startPrev_q <= bus.START;
      stopPrev_q  <= bus.STOP;
      count1_q    <= count1_d;
      stepCnt_q   <= stepCnt_d;
      countDown_q <= countDown_d;
      elapsed_q   <= elapsed_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
    end
  end

  assign bus.COUNT1     = count1_q;
  assign bus.COUNT_DOWN = countDown_q;
  assign bus.ELAPSED    = elapsed_q;
  assign bus.RUNNING    = (state_q == RUN);
  assign bus.WIN        = win_q;
  assign bus.LOSE       = lose_q;

endmodule

// File: tb/tb_countdown_game_ctrl.sv
// Scoreboard bench for the countdown game controller with a round-level reference model.
module tb_countdown_game_ctrl;
  import countdown_game_pkg::*;

  localparam int CPM     = 4;
  localparam int SMS     = 10;
  localparam int NST     = 5;
  localparam int TGT     = 50;
  localparam int TOL     = 2;
  localparam int TIMEOUT = TGT + TOL + 1;

  typedef struct {
    int elapsed;
    bit win;
  } result_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  result_t expQ[$];

  countdown_game_ctrl_if bus();

  countdown_game_ctrl #(
    .CLK_PER_MS (CPM),
    .STEP_MS    (SMS),
    .STEPS      (NST),
    .TARGET_MS  (TGT),
    .TOL_MS     (TOL)
  ) dut (
    .CLK   (clk),
    .RESET (reset),
    .bus   (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Outcome of a round whose STOP is raised j cycles after the START edge is taken.
  function automatic result_t modelRound(input int j);
    result_t r;
    if (j < CPM * TIMEOUT) begin
      r.elapsed = j / CPM;
      r.win     = (r.elapsed >= TGT - TOL) && (r.elapsed <= TGT + TOL);
    end else begin
      r.elapsed = TIMEOUT;
      r.win     = 1'b0;
    end
    return r;
  endfunction

  task automatic applyStimulus(input int j, input bit together, input int doneWait);
    @(negedge clk);
    bus.START = 1'b1;
    expQ.push_back(modelRound(j));
    @(negedge clk);
    bus.START = 1'b0;
    checkOutput("runningAfterStart", bus.RUNNING, 1);
    checkOutput("countDownAfterStart", bus.COUNT_DOWN, NST);
    checkOutput("count1AfterStart", bus.COUNT1, 0);
    for (int i = 1; i <= j; i++) begin
      @(negedge clk);
      if (i == 40) begin
        checkOutput("count1At40", bus.COUNT1, 10);
        checkOutput("countDownAt40", bus.COUNT_DOWN, NST - 1);
      end
    end
    bus.STOP  = 1'b1;
    bus.START = together;
    @(negedge clk);
    bus.STOP  = 1'b0;
    bus.START = 1'b0;
    repeat (doneWait) @(negedge clk);
  endtask

  task automatic resetMidRound();
    @(negedge clk);
    bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    repeat (120) @(negedge clk);
    checkOutput("count1BeforeReset", bus.COUNT1, 30);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("resetRunning", bus.RUNNING, 0);
    checkOutput("resetCount1", bus.COUNT1, 0);
    checkOutput("resetCountDown", bus.COUNT_DOWN, 0);
    checkOutput("resetElapsed", bus.ELAPSED, 0);
    checkOutput("resetWin", bus.WIN, 0);
    checkOutput("resetLose", bus.LOSE, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on entry to DONE, checks holding and per-state invariants.
  initial begin
    bit      prevRun = 1'b0;
    bit      inDone  = 1'b0;
    result_t cur;
    cur.elapsed = 0;
    cur.win     = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.RUNNING) begin
        inDone = 1'b0;
        checkOutput("countDownInRun", bus.COUNT_DOWN,
                    (bus.COUNT1 < NST * SMS) ? NST - int'(bus.COUNT1) / SMS : 0);
        checkOutput("winInRun", bus.WIN, 0);
        checkOutput("loseInRun", bus.LOSE, 0);
      end else if (bus.WIN || bus.LOSE) begin
        if (prevRun) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpectedDone", 1, 0);
          end else begin
            cur = expQ.pop_front();
          end
          inDone = 1'b1;
        end
        if (inDone) begin
          checkOutput("doneElapsed", bus.ELAPSED, cur.elapsed);
          checkOutput("doneCount1", bus.COUNT1, cur.elapsed);
          checkOutput("doneWin", bus.WIN, cur.win);
          checkOutput("doneLose", bus.LOSE, !cur.win);
        end
        checkOutput("countDownInDone", bus.COUNT_DOWN, 0);
      end else begin
        inDone = 1'b0;
        if (!reset) begin
          checkOutput("idleCount1", bus.COUNT1, 0);
          checkOutput("idleElapsed", bus.ELAPSED, 0);
          checkOutput("idleCountDown", bus.COUNT_DOWN, 0);
        end
      end
      prevRun = bus.RUNNING;
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    int  j;
    bit  together;
    bus.START = 1'b1;
    bus.STOP  = 1'b0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("startHeldThroughReset", bus.RUNNING, 0);
    bus.START = 1'b0;
    repeat (2) @(negedge clk);

    bus.STOP = 1'b1;
    @(negedge clk);
    bus.STOP = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("stopInIdleRunning", bus.RUNNING, 0);
    checkOutput("stopInIdleLose", bus.LOSE, 0);

    applyStimulus(196, 1'b0, 100);
    applyStimulus(188, 1'b0, 5);
    applyStimulus(215, 1'b0, 5);
    applyStimulus(240, 1'b0, 5);
    applyStimulus(100, 1'b1, 5);
    applyStimulus(211, 1'b0, 5);
    applyStimulus(0, 1'b0, 5);
    resetMidRound();
    applyStimulus(200, 1'b0, 5);

    for (int r = 0; r < 10; r++) begin
      j = $urandom_range(0, 250);
      together = (j < CPM * TIMEOUT) && ($urandom_range(0, 3) == 0);
      applyStimulus(j, together, $urandom_range(1, 6));
    end

    repeat (5) @(negedge clk);
    checkOutput("scoreboardDrained", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
